// File: rtl/riscv_wb.sv
// Writeback stage and register file: ALU results are written directly, loads
// go through a request/ack handshake with data memory before writeback.
module riscv_wb #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            ex_valid,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] result,
  input  logic [2:0]      funct3,
  input  logic            memfetch,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] regs [32],
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exception
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [4:0]      r_rd;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [XLEN-1:0] r_addr;

  logic            w_legal, w_start, w_we, w_exc, w_last;
  logic [4:0]      w_wrd;
  logic [XLEN-1:0] w_wdata, w_load_data;

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return ~off[0];
      3'b010:         return off == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   return {{(XLEN-8){~f3[2] & lane[7]}}, lane[7:0]};
      2'b01:   return {{(XLEN-16){~f3[2] & lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  assign w_legal     = load_legal(funct3, result[1:0]);
  assign w_start     = (r_state == S_IDLE) && ex_valid && memfetch && w_legal;
  assign w_last      = (r_cnt == 4'(TIMEOUT - 1));
  assign w_load_data = load_extend(r_f3, r_off, mem_rdata);
  assign mem_addr    = r_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_WAIT;
      S_WAIT:  if (mem_ack || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (r_state == S_WAIT);
    stall   = (r_state == S_WAIT);
  end

  // Writeback selection: ALU result from IDLE, extended load data from WAIT
  always_comb begin
    w_we    = 1'b0;
    w_exc   = 1'b0;
    w_wrd   = rd;
    w_wdata = result;
    case (r_state)
      S_IDLE: begin
        if (ex_valid && !memfetch)     w_we  = (rd != 5'd0);
        else if (ex_valid && !w_legal) w_exc = 1'b1;
      end
      S_WAIT: begin
        w_wrd   = r_rd;
        w_wdata = w_load_data;
        if (mem_ack)     w_we  = (r_rd != 5'd0);
        else if (w_last) w_exc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exception <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
    end else begin
      if (w_we) begin
        regs[w_wrd] <= w_wdata;
        wb_rd       <= w_wrd;
        wb_data     <= w_wdata;
      end
      wb_we     <= w_we;
      exception <= w_exc;
      if (w_start) begin
        r_cnt  <= '0;
        r_addr <= {result[XLEN-1:2], 2'b00};
      end else if (r_state == S_WAIT && !mem_ack) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Load descriptor is pure data, captured at load start only
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_rd  <= rd;
      r_f3  <= funct3;
      r_off <= result[1:0];
    end
  end

endmodule

// File: tb/tb_riscv_wb.sv
// Bench for riscv_wb: directed cases followed by a random mix of ALU writes,
// loads, illegal loads and timeouts, checked against a register-file model.
module tb_riscv_wb;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst, ex_valid, memfetch, mem_req, mem_ack, stall, wb_we, exception;
  logic [4:0]      rd, wb_rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] result, mem_addr, mem_rdata, wb_data;
  logic [XLEN-1:0] regs [32];

  logic [31:0] m_regs [32];
  int n_cmp = 0;
  int n_err = 0;

  riscv_wb #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .rst(rst), .clk(clk), .ex_valid(ex_valid), .rd(rd), .result(result),
    .funct3(funct3), .memfetch(memfetch), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .regs(regs),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .exception(exception)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== m_regs[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  function automatic int load_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    nb = load_bytes(f3);
    return (nb != 0) && ((int'(addr[1:0]) % nb) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    int nb;
    longint v;
    nb = load_bytes(f3);
    v  = (longint'(w) >> (8 * int'(addr[1:0]))) & ((64'sd1 <<< (8 * nb)) - 1);
    if (!f3[2] && nb < 4 && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
    return v[31:0];
  endfunction

  task automatic garbage;
    ex_valid = 1'($urandom);
    memfetch = 1'($urandom);
    rd       = 5'($urandom);
    result   = $urandom;
    funct3   = 3'($urandom);
  endtask

  task automatic do_alu(input logic [4:0] r, input logic [31:0] v);
    ex_valid  = 1'b1;
    memfetch  = 1'b0;
    rd        = r;
    result    = v;
    funct3    = 3'($urandom);
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    step;
    ex_valid = 1'b0;
    mem_ack  = 1'b0;
    if (r != 5'd0) m_regs[r] = v;
    chk("alu_reg", regs[r], m_regs[r]);
    chk("alu_x0", regs[0], 32'd0);
    chk("alu_we", 32'(wb_we), 32'(r != 5'd0));
    if (r != 5'd0) begin
      chk("alu_wb_rd", 32'(wb_rd), 32'(r));
      chk("alu_wb_data", wb_data, v);
    end
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_exc", 32'(exception), 32'd0);
  endtask

  task automatic do_load(input logic [4:0] r, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] w, input int delay);
    logic legal;
    legal    = ref_legal(f3, addr);
    ex_valid = 1'b1;
    memfetch = 1'b1;
    rd       = r;
    result   = addr;
    funct3   = f3;
    mem_ack  = 1'b0;
    step;
    ex_valid = 1'b0;
    memfetch = 1'b0;
    if (!legal) begin
      chk("ill_exc", 32'(exception), 32'd1);
      chk("ill_req", 32'(mem_req), 32'd0);
      chk("ill_stall", 32'(stall), 32'd0);
      chk("ill_we", 32'(wb_we), 32'd0);
      step;
      chk("ill_exc_pulse", 32'(exception), 32'd0);
      chk("ill_req2", 32'(mem_req), 32'd0);
      check_regs("ill_regs");
      return;
    end
    chk("ld_req", 32'(mem_req), 32'd1);
    chk("ld_stall", 32'(stall), 32'd1);
    chk("ld_exc", 32'(exception), 32'd0);
    chk("ld_addr", mem_addr, addr & ~32'd3);
    if (delay < TIMEOUT) begin
      for (int k = 0; k < delay; k++) begin
        garbage;
        step;
        chk("ld_wait_req", 32'(mem_req), 32'd1);
        chk("ld_wait_stall", 32'(stall), 32'd1);
      end
      ex_valid  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = w;
      step;
      mem_ack = 1'b0;
      if (r != 5'd0) m_regs[r] = ref_load(f3, addr, w);
      chk("ld_done_req", 32'(mem_req), 32'd0);
      chk("ld_done_stall", 32'(stall), 32'd0);
      chk("ld_done_exc", 32'(exception), 32'd0);
      chk("ld_we", 32'(wb_we), 32'(r != 5'd0));
      chk("ld_reg", regs[r], m_regs[r]);
      if (r != 5'd0) begin
        chk("ld_wb_rd", 32'(wb_rd), 32'(r));
        chk("ld_wb_data", wb_data, m_regs[r]);
      end
      check_regs("ld_regs");
    end else begin
      for (int k = 0; k < TIMEOUT - 1; k++) begin
        garbage;
        step;
        chk("to_wait_req", 32'(mem_req), 32'd1);
        chk("to_wait_exc", 32'(exception), 32'd0);
      end
      ex_valid = 1'b0;
      step;
      chk("to_exc", 32'(exception), 32'd1);
      chk("to_req", 32'(mem_req), 32'd0);
      chk("to_stall", 32'(stall), 32'd0);
      chk("to_we", 32'(wb_we), 32'd0);
      step;
      chk("to_exc_pulse", 32'(exception), 32'd0);
      check_regs("to_regs");
    end
  endtask

  initial begin
    logic [4:0]  r;
    logic [31:0] a, w;
    logic [2:0]  f;
    int          d;

    rst = 1'b1; ex_valid = 1'b0; memfetch = 1'b0; rd = '0; result = '0;
    funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    step;
    step;
    rst = 1'b0;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", 32'(exception), 32'd0);
    check_regs("rst_regs");

    do_alu(5'd5, 32'd42);
    do_alu(5'd0, 32'd7);
    do_load(5'd6, 32'h10, 3'b010, 32'hDEADBEEF, 2);
    do_load(5'd7, 32'h13, 3'b000, 32'h80000000, 0);
    do_load(5'd8, 32'h13, 3'b100, 32'h80000000, 1);
    do_load(5'd9, 32'h3, 3'b101, 32'h12345678, 0);
    do_load(5'd12, 32'h22, 3'b001, 32'h8001_7FFF, 0);
    do_load(5'd13, 32'h22, 3'b101, 32'h8001_7FFF, 14);
    do_load(5'd10, 32'h40, 3'b010, 32'h0BADF00D, TIMEOUT);
    do_load(5'd11, 32'h44, 3'b011, 32'h0, 0);

    repeat (80) begin
      r = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_alu(r, $urandom);
      end else begin
        a = $urandom;
        w = $urandom;
        f = 3'($urandom);
        d = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4);
        do_load(r, a, f, w, d);
      end
    end
    check_regs("rand_regs");

    ex_valid = 1'b1; memfetch = 1'b1; rd = 5'd11; result = 32'h20; funct3 = 3'b010;
    step;
    ex_valid = 1'b0; memfetch = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    chk("rstw_req", 32'(mem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_exc", 32'(exception), 32'd0);
    chk("rstw_we", 32'(wb_we), 32'd0);
    check_regs("rstw_regs");
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step;
    mem_ack = 1'b0;
    chk("rstw_late_ack_we", 32'(wb_we), 32'd0);
    check_regs("rstw_late_ack_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
